mandel_pixel_engine: RTL
========================

Name: mandel_pixel_engine

Overview:
- Synthesizable fixed-point Mandelbrot iteration engine that sits directly upstream of the pixel output streamer.
- Accepts one complex coordinate c = (cr, ci) per handshake and iterates z = z^2 + c at one iteration per clock.
- Returns the escape iteration count, the palette-mapped RGB colour and a pass-through tag.
- The downstream streamer packs `out_rgb` into tdata[31:8] and drives tuser/tlast from the tag.

Parameters:
- W, 32: coordinate/state width, signed two's complement.
- FRAC, 28: fractional bits (Q4.28); integer range ±8.
- MAX_ITER, 255: iteration limit; also the out_iter value reported for points inside the set.
- TAG_W, 2: width of the opaque tag carried with each pixel (bit0 = first/tuser, bit1 = last/tlast).

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_cr  in  W  real part of c, Q4.28.
- in_ci  in  W  imaginary part of c, Q4.28.
- in_tag  in  TAG_W  tag, captured with c.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- out_iter  out  8  escape iteration, or MAX_ITER if the point did not escape.
- out_rgb  out  24  {r,g,b} palette colour.
- out_tag  out  TAG_W  captured tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Clock and reset:
  - One clock, aclk. Reset areset is asynchronous and active-high.
  - While areset is high: state = IDLE, in_ready = 0, out_valid = 0, out_iter = 0, out_rgb = 0, out_tag = 0, and internal zr, zi, i are cleared.
  - in_ready rises on the first clock edge after areset deasserts.
- FSM states and transitions:
  - IDLE: in_ready = 1. On an edge with in_valid = 1, capture cr, ci and tag; set zr = zi = 0 and i = 0; go to ITER.
  - ITER: in_ready = 0. Each cycle compute zr2 = zr*zr and zi2 = zi*zi from the full 2W products, kept at Q(2W-2*FRAC).FRAC without truncation of integer bits.
    - If zr2 + zi2 > 4.0 (strictly greater; equal to 4.0 does not escape): out_iter = i, go to DONE.
    - Else if i == MAX_ITER-1: out_iter = MAX_ITER, go to DONE.
    - Else: zr = (zr2 - zi2) + cr; zi = ((zr*zi) >>> (FRAC-1)) + ci; i = i+1.
  - DONE: out_valid = 1; out_iter, out_rgb and out_tag are held stable. On an edge with out_ready = 1, go to IDLE. out_valid drops and in_ready rises on the same edge.
- Arithmetic:
  - All right shifts are arithmetic and truncate toward −inf.
  - New zr and zi are taken as the low W bits after the shift and add.
  - No saturation logic. Inputs must satisfy |cr|, |ci| < 3.5, which keeps z inside ±8 given the escape test.
- Palette, registered on entry to DONE:
  - If out_iter == MAX_ITER, out_rgb = 24'h000000.
  - Otherwise r = iter, g = (iter*2) mod 256, b = 255 - iter.
- Latency:
  - Acceptance edge is E0. A point escaping at i = k has out_valid high after edge E(k+1).
  - A non-escaping point has out_valid high after edge E(MAX_ITER).
  - No overlap: the next request is accepted no earlier than the edge after the output handshake.
- Backpressure: out_valid stays asserted and all outputs stay constant indefinitely while out_ready = 0.
- Boundary conditions:
  - in_valid during ITER or DONE is ignored; the request is not lost, because in_ready = 0.
  - out_ready high while not in DONE has no effect.
  - areset asserted mid-ITER or mid-DONE aborts the pixel immediately. No output is produced for it and no stale out_valid appears after reset.

Test Plan:
- Reset: hold areset 3 cycles, then release -> out_valid = 0 and all outputs 0 throughout; in_ready = 1 one edge after release.
- c = (1.0, 0.0), tag = 2'b01 -> out_iter = 3, out_rgb = 24'h0306FC, out_tag = 2'b01, out_valid high 4 edges after acceptance.
- c = (0.0, 2.0) -> out_iter = 2, out_rgb = 24'h0204FD. Exercises the zi path and the sign of the 2·zr·zi term.
- c = (-2.0, 0.0) -> |z|^2 sits at exactly 4.0 and never escapes; out_iter = 255, out_rgb = 0, out_valid after 255 edges. Exercises the strict > comparison.
- Backpressure: run the c = (1.0, 0.0) case with out_ready = 0 for 10 cycles, and pulse in_valid with a new c during the stall -> outputs stay stable and in_ready = 0. After out_ready = 1 for one edge, the new request is accepted only once in_ready is high.
- Reset mid-operation: start c = (0,0), assert areset at iteration 50 and release, then send c = (1.0, 0.0) -> the only result observed is out_iter = 3; no result appears for the aborted pixel.

Source files
------------

// File: rtl/mandel_pixel_engine.sv
// Fixed-point Mandelbrot iteration engine: one z = z^2 + c step per clock,
// returns escape count, palette colour and the pass-through tag.
//
// state | meaning
// IDLE  | ready for a new coordinate (in_ready high after first post-reset edge)
// ITER  | iterating; escape test and z update each cycle
// DONE  | result presented, held until out_ready
module mandel_pixel_engine #(
    parameter int W        = 32,
    parameter int FRAC     = 28,
    parameter int MAX_ITER = 255,
    parameter int TAG_W    = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [W-1:0]     in_cr,
    input  logic [W-1:0]     in_ci,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_iter,
    output logic [23:0]      out_rgb,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [2*W-1:0] ONE_X   = 1;
    localparam logic signed [2*W-1:0] FOUR    = ONE_X <<< (FRAC + 2);
    localparam logic [7:0]            MAX_IT8 = 8'(MAX_ITER);
    localparam logic [7:0]            LAST_IT = 8'(MAX_ITER - 1);

    state_t                  state_q;
    logic signed [W-1:0]     cr_q, ci_q, zr_q, zi_q;
    logic signed [W-1:0]     zr_d, zi_d;
    logic [7:0]              iter_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    in_ready_q, out_valid_q;
    logic [7:0]              out_iter_q;
    logic [23:0]             out_rgb_q;
    logic [TAG_W-1:0]        out_tag_q;

    logic signed [2*W-1:0]   zr_x, zi_x;
    logic signed [2*W-1:0]   prod_rr, prod_ii, prod_ri;
    logic signed [2*W-1:0]   zr2, zi2, mag;
    logic                    escape;

    // Full-width products; squares are rescaled to Q(2W-2FRAC).FRAC so the
    // magnitude test sees every integer bit.
    always_comb begin
        zr_x    = {{W{zr_q[W-1]}}, zr_q};
        zi_x    = {{W{zi_q[W-1]}}, zi_q};
        prod_rr = zr_x * zr_x;
        prod_ii = zi_x * zi_x;
        prod_ri = zr_x * zi_x;
        zr2     = prod_rr >>> FRAC;
        zi2     = prod_ii >>> FRAC;
        mag     = zr2 + zi2;
        escape  = (mag > FOUR);
        zr_d    = zr2[W-1:0] - zi2[W-1:0] + cr_q;
        zi_d    = W'(prod_ri >>> (FRAC - 1)) + ci_q;
    end

    function automatic logic [23:0] palette(input logic [7:0] it);
        logic [23:0] rgb;
        if (it == MAX_IT8) begin
            rgb = 24'h000000;
        end else begin
            rgb = {it, it[6:0], 1'b0, 8'hFF - it};
        end
        return rgb;
    endfunction

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            cr_q        <= '0;
            ci_q        <= '0;
            zr_q        <= '0;
            zi_q        <= '0;
            iter_q      <= '0;
            tag_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_iter_q  <= '0;
            out_rgb_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        cr_q       <= in_cr;
                        ci_q       <= in_ci;
                        tag_q      <= in_tag;
                        zr_q       <= '0;
                        zi_q       <= '0;
                        iter_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (escape) begin
                        out_iter_q  <= iter_q;
                        out_rgb_q   <= palette(iter_q);
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (iter_q == LAST_IT) begin
                        out_iter_q  <= MAX_IT8;
                        out_rgb_q   <= palette(MAX_IT8);
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        zr_q   <= zr_d;
                        zi_q   <= zi_d;
                        iter_q <= iter_q + 8'd1;
                    end
                end
                S_DONE: begin
                    // in_ready rises on the same edge the result is taken
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_iter  = out_iter_q;
    assign out_rgb   = out_rgb_q;
    assign out_tag   = out_tag_q;

endmodule
